mips_data_stall_bridge: RTL and testbench

Bridges the CPU core's combinational-read / single-cycle-write data port to a variable-latency, req/ack data memory, and generates the core's clock-enable so the core freezes while an access is outstanding. Sits directly downstream of the core's data port (core `data_*` signals in, memory `mem_*` signals out). It also gates the externally supplied run enable. A timeout counter guarantees forward progress if the memory never acknowledges.

---
 rtl/mips_data_stall_bridge.sv | 94 +++++++++
 tb/tb_mips_data_stall_bridge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_stall_bridge.sv
// rtl/mips_data_stall_bridge.sv - core data port to req/ack memory bridge with core clock-enable stall
module mips_data_stall_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_enable,
    output logic        cpu_clk_enable,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          req;

    assign req            = data_read | data_write;
    assign data_readdata  = rdata_q;
    // The core must drive data_read/data_write from its own registers: this path is combinational.
    assign cpu_clk_enable = run_enable & (((state == IDLE) & ~req) | (state == DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (data_address[1:0] != 2'b00) begin
                            err     <= 1'b1;
                            rdata_q <= ERR_DATA;
                            state   <= DONE;
                        end else begin
                            mem_addr  <= data_address[31:2];
                            mem_wdata <= data_writedata;
                            mem_we    <= data_write;
                            mem_req   <= 1'b1;
                            cnt       <= CW'(TIMEOUT);
                            state     <= WAIT;
                            // Simultaneous read and write proceeds as a write but is flagged.
                            if (data_read & data_write)
                                err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            rdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt <= CW'(1)) begin
                        err     <= 1'b1;
                        rdata_q <= ERR_DATA;
                        cnt     <= '0;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (run_enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_data_stall_bridge.sv
// tb/tb_mips_data_stall_bridge.sv - scoreboard bench for mips_data_stall_bridge
module tb_mips_data_stall_bridge;

    localparam int          TO      = 4;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_enable;
    logic        cpu_clk_enable;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          req_cycles;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model_rdata;
    logic        model_err;

    int          ack_after = 0;
    logic [31:0] mem_val = '0;
    logic        stray = 1'b0;
    int          wait_cnt = 0;

    mips_data_stall_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR_VAL)) dut (
        .clk(clk), .reset(reset), .run_enable(run_enable), .cpu_clk_enable(cpu_clk_enable),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Memory responder: acks in the ack_after-th cycle of mem_req (0 = never).
    always @(negedge clk) begin
        if (mem_req) wait_cnt = wait_cnt + 1;
        else         wait_cnt = 0;
        mem_ack   = stray | (mem_req && ack_after != 0 && wait_cnt == ack_after);
        mem_rdata = mem_val;
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        model_err   = 1'b0;
    endtask

    task automatic do_access(input string name, input logic [31:0] addr, input logic rd,
                             input logic wr, input logic [31:0] wd, input int ack_k,
                             input logic [31:0] rval);
        exp_t e;
        exp_t got;
        int   stalls;
        int   reqc;
        if (addr[1:0] != 2'b00) begin
            e.stalls = 1; e.req_cycles = 0; model_rdata = ERR_VAL; model_err = 1'b1;
        end else if (ack_k == 0 || ack_k > TO) begin
            e.stalls = TO + 1; e.req_cycles = TO; model_rdata = ERR_VAL; model_err = 1'b1;
        end else begin
            e.stalls = ack_k + 1; e.req_cycles = ack_k;
            if (!wr) model_rdata = rval;
            if (rd && wr) model_err = 1'b1;
        end
        e.rdata = model_rdata;
        e.err   = model_err;
        sb.push_back(e);
        ack_after = ack_k;
        mem_val   = rval;
        @(negedge clk);
        data_address = addr; data_read = rd; data_write = wr; data_writedata = wd;
        #1;
        stalls = 0;
        reqc   = 0;
        while (cpu_clk_enable !== 1'b1 && stalls < 100) begin
            stalls++;
            if (mem_req === 1'b1) begin
                reqc++;
                checks++;
                if (mem_addr !== addr[31:2] || mem_we !== wr || mem_wdata !== wd) begin
                    errors++;
                    $display("FAIL %s mem_hold: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                             name, mem_addr, mem_we, mem_wdata, addr[31:2], wr, wd);
                end
            end
            @(negedge clk);
            #1;
        end
        got = sb.pop_front();
        checks++;
        if (stalls !== got.stalls) begin
            errors++;
            $display("FAIL %s stalls: got %0d required %0d", name, stalls, got.stalls);
        end
        checks++;
        if (reqc !== got.req_cycles) begin
            errors++;
            $display("FAIL %s req_cycles: got %0d required %0d", name, reqc, got.req_cycles);
        end
        checks++;
        if (data_readdata !== got.rdata) begin
            errors++;
            $display("FAIL %s readdata: got %h required %h", name, data_readdata, got.rdata);
        end
        checks++;
        if (err !== got.err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", name, err, got.err);
        end
        data_read = 1'b0; data_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; run_enable = 1'b1;
        data_address = '0; data_read = 1'b0; data_write = 1'b0; data_writedata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_rdata = '0; model_err = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, data_readdata, err} !== 96'd0) begin
            errors++;
            $display("FAIL reset_values: req=%b we=%b addr=%h wdata=%h rdata=%h err=%b required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, data_readdata, err);
        end
        checks++;
        if (cpu_clk_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_enable_idle: got %b required 1", cpu_clk_enable);
        end
        data_read = 1'b1;
        #1;
        checks++;
        if (cpu_clk_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_enable_req: got %b required 0", cpu_clk_enable);
        end
        apply_reset();
        data_read = 1'b0;
    endtask

    task automatic test_read_fast();
        do_access("read_fast", 32'h0000_0040, 1'b1, 1'b0, 32'h0, 1, 32'h1234_5678);
    endtask

    task automatic test_write_slow();
        do_access("write_slow", 32'h0000_0010, 1'b0, 1'b1, 32'hCAFE_F00D, 3, 32'h0BAD_0BAD);
    endtask

    task automatic test_timeout();
        do_access("timeout", 32'h0000_0100, 1'b1, 1'b0, 32'h0, 0, 32'h1111_2222);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky_err: got %b required 1", err);
        end
    endtask

    task automatic test_reset_mid();
        ack_after = 0;
        @(negedge clk);
        data_address = 32'h0000_0200; data_read = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_in_wait: mem_req got %b required 1", mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; data_read = 1'b0;
        model_rdata = '0; model_err = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || err !== 1'b0 || cpu_clk_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: req=%b err=%b en=%b required 0 0 1",
                     mem_req, err, cpu_clk_enable);
        end
        stray = 1'b1; mem_val = 32'h7777_7777;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || err !== 1'b0 || data_readdata !== 32'h0 || cpu_clk_enable !== 1'b1) begin
            errors++;
            $display("FAIL stray_ack: req=%b err=%b rdata=%h en=%b required 0 0 00000000 1",
                     mem_req, err, data_readdata, cpu_clk_enable);
        end
        do_access("after_stray", 32'h0000_0044, 1'b1, 1'b0, 32'h0, 2, 32'h3C3C_3C3C);
    endtask

    task automatic test_misaligned();
        do_access("misaligned", 32'h0000_0002, 1'b1, 1'b0, 32'h0, 1, 32'h4444_4444);
    endtask

    task automatic test_rw_both();
        apply_reset();
        do_access("rw_both", 32'h0000_0080, 1'b1, 1'b1, 32'h5555_AAAA, 2, 32'h9999_9999);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        apply_reset();
        run_enable = 1'b0;
        model_rdata = 32'hA5A5_0001;
        e.rdata = model_rdata; e.err = 1'b0; e.stalls = 0; e.req_cycles = 0;
        sb.push_back(e);
        ack_after = 1; mem_val = 32'hA5A5_0001;
        @(negedge clk);
        data_address = 32'h0000_0020; data_read = 1'b1;
        repeat (2) @(negedge clk);
        got = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (cpu_clk_enable !== 1'b0 || data_readdata !== got.rdata || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_done[%0d]: en=%b rdata=%h req=%b required 0 %h 0",
                         i, cpu_clk_enable, data_readdata, mem_req, got.rdata);
            end
            @(negedge clk);
        end
        run_enable = 1'b1; mem_val = 32'h5A5A_0002;
        model_rdata = 32'h5A5A_0002;
        e.rdata = model_rdata;
        sb.push_back(e);
        #1;
        checks++;
        if (cpu_clk_enable !== 1'b1) begin
            errors++;
            $display("FAIL release_enable: got %b required 1", cpu_clk_enable);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cpu_clk_enable !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: en=%b req=%b required 0 0", cpu_clk_enable, mem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cpu_clk_enable !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait: en=%b req=%b required 0 1", cpu_clk_enable, mem_req);
        end
        @(negedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (cpu_clk_enable !== 1'b1 || data_readdata !== got.rdata || err !== got.err) begin
            errors++;
            $display("FAIL b2b_done: en=%b rdata=%h err=%b required 1 %h %b",
                     cpu_clk_enable, data_readdata, err, got.rdata, got.err);
        end
        data_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_fast();
        test_write_slow();
        test_timeout();
        test_reset_mid();
        test_misaligned();
        test_rw_both();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
